mem_port_arbiter: RTL and testbench

//  Shares one single-port unified instruction/data memory between the fetch stage (IF) and the memory stage (DM)
//  of the Y86-64 pipeline. Grants one access at a time, tracks fixed memory latency, returns read data to the owner.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter_lat_tracker.sv | 72 +++++++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the Y86-64 unified memory port: arbiter states, owner codes, latency limits.
// Also pulled in by memory.v and pipectrl.v.
package y86_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_CNT_W   = 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF and DM stages, the arbiter and the single memory port.
// slave = arbiter view, master = pipeline stages plus memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              arb_stall_f;
  logic              arb_stall_m;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, arb_stall_f, arb_stall_m, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, arb_stall_f, arb_stall_m, busy
  );
endinterface

// File: rtl/mem_port_arbiter_lat_tracker.sv
// Tracks the single in-flight access: loads the latency count on issue, latches owner/write flag,
// and flags the response cycle MEM_LAT cycles after issue. No backpressure; a new issue may land on the response cycle.
module mem_lat_tracker
  import y86_mem_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   issue,
  input  owner_t issue_owner,
  input  logic   issue_we,
  output logic   busy,
  output logic   resp_fire,
  output owner_t resp_owner,
  output logic   resp_we
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  state_t                 state_q, state_d;
  logic   [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  owner_t                 owner_q, owner_d;
  logic                   we_q, we_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      owner_q   <= OWN_NONE;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    resp_fire = (state_q == ST_WAIT) && (lat_cnt_q == '0);
    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          we_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Issue only arrives when the port is free, so it may override the response-cycle return to IDLE.
    if (issue) begin
      state_d   = ST_WAIT;
      lat_cnt_d = LAT_LOAD;
      owner_d   = issue_owner;
      we_d      = issue_we;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign resp_owner = owner_q;
  assign resp_we    = we_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and memory stage; response MEM_LAT cycles after issue, back-to-back capable.
// Losers are held off via arb_stall_f/m; DM has priority until STARVE_MAX streak. Optional MEM_ARB_PERF_EN adds perf counters.
module mem_port_arbiter
  import y86_mem_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_if_wait,
  output logic [31:0]          perf_dm_wait,
  output logic [31:0]          perf_access
`endif
);

  // Out-of-range latencies are clamped so the 4-bit counter can never wrap.
  localparam int LAT_EFF  = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                            (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX_V = STREAK_W'(STARVE_MAX);

  logic                busy_w, resp_fire, resp_we;
  owner_t              resp_owner, issue_owner;
  logic                if_rvalid_w, dm_rvalid_w, if_elig, dm_elig;
  logic                port_free, dm_win, if_win, issue, issue_we;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

  mem_lat_tracker #(.MEM_LAT(LAT_EFF)) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_owner(issue_owner),
    .issue_we   (issue_we),
    .busy       (busy_w),
    .resp_fire  (resp_fire),
    .resp_owner (resp_owner),
    .resp_we    (resp_we)
  );

  always_comb begin
    if_rvalid_w = rst_n && resp_fire && (resp_owner == OWN_IF);
    dm_rvalid_w = rst_n && resp_fire && (resp_owner == OWN_DM);
    // A requester still holding req on its own response cycle is finishing, not asking again.
    if_elig     = bus.if_req && !if_rvalid_w;
    dm_elig     = bus.dm_req && !dm_rvalid_w;
    port_free   = rst_n && (!busy_w || resp_fire);
    dm_win      = port_free && dm_elig && ((streak_q < STREAK_MAX_V) || !if_elig);
    if_win      = port_free && if_elig && !dm_win;
    issue       = dm_win || if_win;
    issue_owner = dm_win ? OWN_DM : (if_win ? OWN_IF : OWN_NONE);
    issue_we    = dm_win && bus.dm_we;

    streak_d = streak_q;
    if (dm_win) begin
      streak_d = (streak_q == STREAK_MAX_V) ? streak_q : streak_q + STREAK_W'(1);
    end else if (if_win || (port_free && !bus.dm_req)) begin
      streak_d = '0;
    end

    if_rdata_d = if_rvalid_w ? bus.mem_rdata : if_rdata_q;
    dm_rdata_d = dm_rvalid_w ? (resp_we ? '0 : bus.mem_rdata) : dm_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_gnt      = if_win;
  assign bus.dm_gnt      = dm_win;
  assign bus.if_rvalid   = if_rvalid_w;
  assign bus.dm_rvalid   = dm_rvalid_w;
  assign bus.if_rdata    = if_rdata_d;
  assign bus.dm_rdata    = dm_rdata_d;
  assign bus.mem_en      = issue;
  assign bus.mem_we      = issue_we;
  assign bus.mem_addr    = dm_win ? bus.dm_addr : (if_win ? bus.if_addr : '0);
  assign bus.mem_wdata   = dm_win ? bus.dm_wdata : '0;
  assign bus.arb_stall_f = bus.if_req && !if_rvalid_w;
  assign bus.arb_stall_m = bus.dm_req && !dm_rvalid_w;
  assign bus.busy        = busy_w;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait_q, perf_if_wait_d;
  logic [31:0] perf_dm_wait_q, perf_dm_wait_d;
  logic [31:0] perf_access_q, perf_access_d;

  always_comb begin
    perf_if_wait_d = bus.arb_stall_f ? sat_inc32(perf_if_wait_q) : perf_if_wait_q;
    perf_dm_wait_d = bus.arb_stall_m ? sat_inc32(perf_dm_wait_q) : perf_dm_wait_q;
    perf_access_d  = issue ? sat_inc32(perf_access_q) : perf_access_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_wait_q <= '0;
      perf_dm_wait_q <= '0;
      perf_access_q  <= '0;
    end else begin
      perf_if_wait_q <= perf_if_wait_d;
      perf_dm_wait_q <= perf_dm_wait_d;
      perf_access_q  <= perf_access_d;
    end
  end

  assign perf_if_wait = perf_if_wait_q;
  assign perf_dm_wait = perf_dm_wait_q;
  assign perf_access  = perf_access_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=2 instance and one MEM_LAT=1 instance, each with a small memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [5:0] obs;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] p_if0, p_dm0, p_acc0, p_if1, p_dm1, p_acc1;
`endif

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_wait(p_if0), .perf_dm_wait(p_dm0), .perf_access(p_acc0)
`endif
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_wait(p_if1), .perf_dm_wait(p_dm1), .perf_access(p_acc1)
`endif
  );

  // Memory models: word i holds {16'h30F3, i, 32'h1357_9BDF}; garbage is returned outside valid slots.
  logic [63:0] mem0 [0:255];
  logic [63:0] mem1 [0:255];
  logic [63:0] p0_s0, p0_s1, p1_s0;
  logic        mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= {16'h30F3, 16'(i), 32'h1357_9BDF};
        mem1[i] <= {16'h30F3, 16'(i), 32'h1357_9BDF};
      end
      mem_ready <= 1'b1;
    end else begin
      p0_s0 <= b.mem_en ? mem0[b.mem_addr[10:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
      p0_s1 <= p0_s0;
      if (b.mem_en && b.mem_we) mem0[b.mem_addr[10:3]] <= b.mem_wdata;
      p1_s0 <= b1.mem_en ? mem1[b1.mem_addr[10:3]] : 64'hBAD1_BAD1_BAD1_BAD1;
      if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[10:3]] <= b1.mem_wdata;
    end
  end

  assign b.mem_rdata  = p0_s1;
  assign b1.mem_rdata = p1_s0;

  task automatic idle(input int n);
    b.if_req = 0; b.dm_req = 0; b.dm_we = 0;
    b1.if_req = 0; b1.dm_req = 0; b1.dm_we = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {b.busy, b.mem_en, b.mem_we, b.if_gnt, b.dm_gnt, b.if_rvalid};
    total++; if (obs !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b want=%b", obs, 6'b0); end
    total++; if (b.if_rdata !== 64'h0) begin bad++; $display("FAIL reset_if_rdata got=%h want=0", b.if_rdata); end
    total++; if (b.dm_rdata !== 64'h0) begin bad++; $display("FAIL reset_dm_rdata got=%h want=0", b.dm_rdata); end
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy_lat1 got=%b want=0", b1.busy); end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    obs = {b.dm_rvalid, b.arb_stall_f, b.arb_stall_m, b.busy, b.mem_en, b.mem_we};
    total++; if (obs !== 6'b0) begin bad++; $display("FAIL post_reset_ctl got=%b want=%b", obs, 6'b0); end
    total++; if (b.mem_addr !== 64'h0 || b.mem_wdata !== 64'h0) begin
      bad++; $display("FAIL post_reset_mem_bus got=%h/%h want=0/0", b.mem_addr, b.mem_wdata);
    end
    @(posedge clk); #1;
  endtask

  // obs = {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we}
  task automatic test_if_only();
    logic [5:0] exp [0:3];
    exp = '{6'b100010, 6'b000000, 6'b010000, 6'b000000};
    for (int c = 0; c < 4; c++) begin
      b.if_req = (c < 3); b.if_addr = 64'h0;
      @(negedge clk);
      obs = {b.if_gnt, b.if_rvalid, b.dm_gnt, b.dm_rvalid, b.mem_en, b.mem_we};
      total++; if (obs !== exp[c]) begin bad++; $display("FAIL if_only c%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 1) begin
        total++; if ({b.busy, b.arb_stall_f} !== 2'b11) begin bad++; $display("FAIL if_only_busy_stall got=%b want=11", {b.busy, b.arb_stall_f}); end
      end
      if (c >= 2) begin
        total++; if (b.if_rdata !== 64'h30F3_0000_1357_9BDF) begin bad++; $display("FAIL if_only_rdata c%0d got=%h want=30f3000013579bdf", c, b.if_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_if_dm_same_cycle();
    logic [5:0] exp [0:5];
    exp = '{6'b001010, 6'b000000, 6'b100110, 6'b000000, 6'b010000, 6'b000000};
    for (int c = 0; c < 6; c++) begin
      b.dm_req = (c <= 2); b.dm_we = 0; b.dm_addr = 64'h100;
      b.if_req = (c <= 4); b.if_addr = 64'h8;
      @(negedge clk);
      obs = {b.if_gnt, b.if_rvalid, b.dm_gnt, b.dm_rvalid, b.mem_en, b.mem_we};
      total++; if (obs !== exp[c]) begin bad++; $display("FAIL if_dm c%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 0) begin
        total++; if (b.mem_addr !== 64'h100) begin bad++; $display("FAIL if_dm_addr0 got=%h want=100", b.mem_addr); end
      end
      if (c == 1) begin
        total++; if (b.arb_stall_f !== 1'b1) begin bad++; $display("FAIL if_dm_stall_f got=%b want=1", b.arb_stall_f); end
      end
      if (c == 2) begin
        total++; if (b.mem_addr !== 64'h8) begin bad++; $display("FAIL if_dm_addr2 got=%h want=8", b.mem_addr); end
        total++; if (b.dm_rdata !== 64'h30F3_0020_1357_9BDF) begin bad++; $display("FAIL if_dm_dm_rdata got=%h want=30f3002013579bdf", b.dm_rdata); end
      end
      if (c == 4) begin
        total++; if (b.if_rdata !== 64'h30F3_0001_1357_9BDF) begin bad++; $display("FAIL if_dm_if_rdata got=%h want=30f3000113579bdf", b.if_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dm_write();
    logic [5:0] exp [0:7];
    exp = '{6'b001011, 6'b000000, 6'b000100, 6'b000000, 6'b001010, 6'b000000, 6'b000100, 6'b000000};
    for (int c = 0; c < 8; c++) begin
      b.dm_req = (c <= 2) || (c >= 4 && c <= 6); b.dm_we = (c <= 2);
      b.dm_addr = 64'h200; b.dm_wdata = 64'h0000_0000_DEAD_BEEF;
      @(negedge clk);
      obs = {b.if_gnt, b.if_rvalid, b.dm_gnt, b.dm_rvalid, b.mem_en, b.mem_we};
      total++; if (obs !== exp[c]) begin bad++; $display("FAIL dm_write c%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 0) begin
        total++; if (b.mem_addr !== 64'h200 || b.mem_wdata !== 64'hDEAD_BEEF) begin
          bad++; $display("FAIL dm_write_bus got=%h/%h want=200/deadbeef", b.mem_addr, b.mem_wdata);
        end
      end
      if (c == 2 || c == 3) begin
        total++; if (b.dm_rdata !== 64'h0) begin bad++; $display("FAIL dm_write_ack_rdata c%0d got=%h want=0", c, b.dm_rdata); end
      end
      if (c == 6) begin
        total++; if (b.dm_rdata !== 64'hDEAD_BEEF) begin bad++; $display("FAIL dm_readback got=%h want=deadbeef", b.dm_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_starvation();
    logic [5:0] exp [0:17];
    exp = '{6'b001010, 6'b000000, 6'b000100, 6'b001010, 6'b000000, 6'b000100,
            6'b001010, 6'b000000, 6'b000100, 6'b001010, 6'b000000, 6'b000100,
            6'b100010, 6'b000000, 6'b011010, 6'b000000, 6'b000100, 6'b000000};
    for (int c = 0; c < 18; c++) begin
      b.dm_req = (c <= 14); b.dm_we = 0; b.dm_addr = 64'h0;
      b.if_req = (c >= 12 && c <= 14); b.if_addr = 64'h0;
      @(negedge clk);
      obs = {b.if_gnt, b.if_rvalid, b.dm_gnt, b.dm_rvalid, b.mem_en, b.mem_we};
      total++; if (obs !== exp[c]) begin bad++; $display("FAIL starve c%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 12) begin
        total++; if (dut.streak_q !== 3'd4) begin bad++; $display("FAIL starve_streak_full got=%0d want=4", dut.streak_q); end
        total++; if (b.arb_stall_m !== 1'b1) begin bad++; $display("FAIL starve_stall_m got=%b want=1", b.arb_stall_m); end
      end
      if (c == 13) begin
        total++; if (dut.streak_q !== 3'd0) begin bad++; $display("FAIL starve_streak_clear got=%0d want=0", dut.streak_q); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_access();
    logic [5:0] exp [0:5];
    logic       bexp [0:5];
    exp  = '{6'b100010, 6'b000000, 6'b100010, 6'b000000, 6'b010000, 6'b000000};
    bexp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      rst_n = (c != 1);
      b.if_req = (c <= 4); b.if_addr = 64'h8;
      @(negedge clk);
      obs = {b.if_gnt, b.if_rvalid, b.dm_gnt, b.dm_rvalid, b.mem_en, b.mem_we};
      total++; if (obs !== exp[c]) begin bad++; $display("FAIL rst_mid c%0d got=%b want=%b", c, obs, exp[c]); end
      total++; if (b.busy !== bexp[c]) begin bad++; $display("FAIL rst_mid_busy c%0d got=%b want=%b", c, b.busy, bexp[c]); end
      if (c == 2) begin
        total++; if (b.if_rdata !== 64'h0) begin bad++; $display("FAIL rst_mid_rdata_clr got=%h want=0", b.if_rdata); end
      end
      if (c == 4) begin
        total++; if (b.if_rdata !== 64'h30F3_0001_1357_9BDF) begin bad++; $display("FAIL rst_mid_rdata got=%h want=30f3000113579bdf", b.if_rdata); end
      end
      @(posedge clk); #1;
    end
    rst_n = 1;
  endtask

  task automatic test_lat1_back_to_back();
    logic [5:0] exp [0:7];
    exp = '{6'b001010, 6'b100110, 6'b011010, 6'b100110, 6'b011010, 6'b100110, 6'b010000, 6'b000000};
    for (int c = 0; c < 8; c++) begin
      b1.if_req = (c <= 6); b1.if_addr = 64'h10;
      b1.dm_req = (c <= 5); b1.dm_we = 0; b1.dm_addr = 64'h18;
      @(negedge clk);
      obs = {b1.if_gnt, b1.if_rvalid, b1.dm_gnt, b1.dm_rvalid, b1.mem_en, b1.mem_we};
      total++; if (obs !== exp[c]) begin bad++; $display("FAIL lat1 c%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 1) begin
        total++; if (b1.dm_rdata !== 64'h30F3_0003_1357_9BDF) begin bad++; $display("FAIL lat1_dm_rdata got=%h want=30f3000313579bdf", b1.dm_rdata); end
      end
      if (c == 2) begin
        total++; if (b1.if_rdata !== 64'h30F3_0002_1357_9BDF) begin bad++; $display("FAIL lat1_if_rdata got=%h want=30f3000213579bdf", b1.if_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 0;
    b.if_req = 0; b.if_addr = '0; b.dm_req = 0; b.dm_we = 0; b.dm_addr = '0; b.dm_wdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
    test_reset();
    idle(2);
    test_if_only();
    idle(2);
    test_if_dm_same_cycle();
    idle(2);
    test_dm_write();
    idle(2);
    test_starvation();
    idle(2);
    test_reset_mid_access();
    idle(2);
    test_lat1_back_to_back();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
